pulse_gen_multi: RTL and testbench
==================================

# pulse_gen_multi

Multi-channel programmable tick generator, the parametrised successor to the single-channel 1 µs pulse generator. It provides NCH independent channels, each with its own terminal count, enable, and periodic or one-shot mode. Channels can optionally be cascaded so that one channel counts the pulses of the channel below it, for example to build 1 µs → 1 ms → 1 s time bases. It sits in the peripheral/timer area and feeds timers, watchdogs and baud or sample strobes.

## Interface
Parameters:
- WD, 16: counter and terminal-count width per channel.
- NCH, 4: number of channels (1..16).

Ports:
- clk  in  1  single system clock; all logic is on posedge clk.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_max_cnt  in  NCH×WD  per-channel terminal count. The period is cfg_max_cnt+1 ticks.
- cfg_enable  in  NCH  per-channel enable (level).
- cfg_oneshot  in  NCH  per-channel mode: 0 = periodic, 1 = one-shot.
- cfg_cascade  in  NCH  per-channel tick source: 0 = clk, 1 = pulse of channel i-1. Bit 0 is ignored.
- start  in  NCH  one-shot start strobe, one clk wide.
- clk_pulse  out  NCH  registered one-cycle pulse at terminal count.
- busy  out  NCH  channel is in state RUN.

## Operation
- Each channel has a 2-state FSM:
  - IDLE: cnt = 0, busy = 0.
  - RUN: counting, busy = 1.
- tick_i:
  - Equals 1 every cycle when the channel counts clk.
  - Equals registered clk_pulse[i-1] when cascaded (cascade build only).
- IDLE → RUN transitions:
  - Periodic: when cfg_enable=1.
  - One-shot: when cfg_enable=1 and start=1.
- In RUN, on tick_i:
  - If cnt >= cfg_max_cnt: cnt ← 0 and clk_pulse ← 1.
    - Periodic: stay in RUN.
    - One-shot: go to IDLE.
  - Otherwise cnt ← cnt+1.
- clk_pulse is 0 in every cycle not described above, so a pulse is exactly one clk wide.
- Terminal compare uses >=, not ==. If cfg_max_cnt is lowered below the current cnt, the channel terminates on its next tick instead of wrapping through 2^WD.
- cfg_max_cnt = 0:
  - Periodic clk-sourced channel: pulse every cycle.
  - Cascaded channel: pulses on every upstream pulse.
- cfg_enable deasserted in any state: next cycle the channel is in IDLE with cnt = 0 and clk_pulse = 0. A pulse already registered in that same edge still appears.
- start while in RUN in one-shot mode retriggers: cnt ← 0 and the channel stays in RUN, with no pulse. If start coincides with the terminal tick, the pulse is emitted and the count restarts (channel stays in RUN).
- start is ignored in periodic mode and when cfg_enable=0.
- cfg_oneshot changing while in RUN takes effect at the next terminal count.
- Channels are fully independent apart from the cascade source.

## Timing
- Reset values: clk_pulse = 0, busy = 0, all cnt = 0, all FSMs in IDLE.
- Periodic, clk-sourced: with enable rising at edge E, busy=1 after E. The first pulse is high in the cycle after edge E+max+1. Pulses then repeat every max+1 cycles.
- One-shot: start sampled at edge S. clk_pulse is high after edge S+max+1, and busy falls at that same edge.
- Cascade: period of channel i = (max_i+1) × period of channel i-1. Each cascade level adds one clk of phase offset relative to its source pulse.
- Reset assertion mid-operation clears all state immediately (asynchronously). After release the channel behaves as if first enabled.

## Configuration
- Macro: PULSE_GEN_MULTI_CASCADE_EN.
- Defined: cfg_cascade selects the tick source as described in Operation.
- Undefined: cfg_cascade is ignored, every channel counts clk, and no inter-channel path is built.

## Structure
- Package pulse_gen_pkg holds:
  - typedef enum logic {PG_IDLE, PG_RUN} pg_state_e.
  - typedef enum logic {PG_PERIODIC, PG_ONESHOT} pg_mode_e.
  - Constant PG_MAX_NCH = 16.
- Sub-module pulse_gen_chan implements one channel: FSM, counter and registered pulse. Its inputs are tick, enable, mode, max_cnt and start; its outputs are pulse and busy.
- pulse_gen_multi is the generate loop plus the cascade tick muxing.

## Test plan
- Channel 0 periodic, max=9, clk source: pulses at cycles 10, 20, 30 after enable; each pulse exactly one cycle wide; busy=1 throughout.
- Channel 1 one-shot, max=4, start at cycle 0: single pulse at cycle 5, busy falls with it; a second start at cycle 20 gives a pulse at cycle 25.
- Retrigger on channel 1: start at 0 and again at 3 gives one pulse at cycle 8 only.
- Channel 0 at max=99 with cnt≈60, max then written to 10: pulse on the next tick, then every 11 cycles.
- Cascade build, ch0 max=3 and ch1 max=2 with cfg_cascade[1]=1: ch1 pulses every 12 cycles, one cycle after the coinciding ch0 pulse. With the macro undefined, ch1 pulses every 3 cycles.
- Assert reset_n mid-count and drop enable mid-count: all outputs are 0 immediately (reset) or after one edge (enable), and no stray pulse appears after release.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared types and limits for the multi-channel tick generator.
// Build option PULSE_GEN_MULTI_CASCADE_EN is consumed by pulse_gen_multi.
package pulse_gen_pkg;

   typedef enum logic {PG_IDLE, PG_RUN} pg_state_e;
   typedef enum logic {PG_PERIODIC, PG_ONESHOT} pg_mode_e;

   localparam int PG_MAX_NCH = 16;

endpackage

// File: rtl/pulse_gen_chan.sv
// One tick-generator channel: IDLE/RUN FSM, terminal counter and registered pulse.
module pulse_gen_chan
   import pulse_gen_pkg::*;
#(
   parameter int WD = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          tick,
   input  logic          enable,
   input  logic          mode,
   input  logic [WD-1:0] max_cnt,
   input  logic          start,
   output logic          pulse,
   output logic          busy
);

   pg_state_e     state;
   pg_mode_e      mode_e;
   logic [WD-1:0] cnt;
   logic          terminal;
   logic          retrigger;

   assign mode_e    = pg_mode_e'(mode);
   // >= so a terminal count lowered below cnt ends the period instead of wrapping.
   assign terminal  = tick && (cnt >= max_cnt);
   assign retrigger = (mode_e == PG_ONESHOT) && start;
   assign busy      = (state == PG_RUN);

   // NOTE: state is updated with non-blocking assignments only, so every
   // right-hand side sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= PG_IDLE;
         cnt   <= '0;
         pulse <= 1'b0;
      end else if (!enable) begin
         state <= PG_IDLE;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         pulse <= 1'b0;
         case (state)
            PG_IDLE: begin
               cnt <= '0;
               if (mode_e == PG_PERIODIC || start) state <= PG_RUN;
            end
            PG_RUN: begin
               if (terminal) begin
                  cnt   <= '0;
                  pulse <= 1'b1;
                  // A start landing on the terminal tick re-arms the one-shot.
                  if (mode_e == PG_ONESHOT && !start) state <= PG_IDLE;
               end else if (retrigger) begin
                  cnt <= '0;
               end else if (tick) begin
                  cnt <= cnt + WD'(1);
               end
            end
            default: state <= PG_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pulse_gen_multi.sv
// NCH independent tick-generator channels with optional cascading.
// Define PULSE_GEN_MULTI_CASCADE_EN to let channel i count pulses of channel i-1.
module pulse_gen_multi
   import pulse_gen_pkg::*;
#(
   parameter int WD  = 16,
   parameter int NCH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NCH*WD-1:0] cfg_max_cnt,
   input  logic [NCH-1:0]    cfg_enable,
   input  logic [NCH-1:0]    cfg_oneshot,
   input  logic [NCH-1:0]    cfg_cascade,
   input  logic [NCH-1:0]    start,
   output logic [NCH-1:0]    clk_pulse,
   output logic [NCH-1:0]    busy
);

   logic [NCH-1:0] tick;
   logic           unused_cascade;

   if (NCH < 1 || NCH > PG_MAX_NCH) begin : g_bad_nch
      $error("pulse_gen_multi: NCH must be in 1..16");
   end

`ifdef PULSE_GEN_MULTI_CASCADE_EN
   // Channel 0 has no upstream source, so its select bit has no meaning.
   assign unused_cascade = cfg_cascade[0];
`else
   assign unused_cascade = ^cfg_cascade;
`endif

   for (genvar i = 0; i < NCH; i++) begin : g_chan
`ifdef PULSE_GEN_MULTI_CASCADE_EN
      if (i == 0) begin : g_src_clk
         assign tick[i] = 1'b1;
      end else begin : g_src_mux
         // Upstream pulse is already registered, giving one clk of phase offset per level.
         assign tick[i] = cfg_cascade[i] ? clk_pulse[i-1] : 1'b1;
      end
`else
      assign tick[i] = 1'b1;
`endif

      pulse_gen_chan #(
         .WD (WD)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .tick    (tick[i]),
         .enable  (cfg_enable[i]),
         .mode    (cfg_oneshot[i]),
         .max_cnt (cfg_max_cnt[i*WD +: WD]),
         .start   (start[i]),
         .pulse   (clk_pulse[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: expected pulse cycles are queued at stimulus
// time and compared against clk_pulse on every cycle.
module tb_pulse_gen_multi;

   localparam int WD  = 16;
   localparam int NCH = 4;

   typedef struct {
      int cyc;
      int ch;
   } ev_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NCH*WD-1:0] cfg_max_cnt;
   logic [NCH-1:0]    cfg_enable;
   logic [NCH-1:0]    cfg_oneshot;
   logic [NCH-1:0]    cfg_cascade;
   logic [NCH-1:0]    start;
   logic [NCH-1:0]    clk_pulse;
   logic [NCH-1:0]    busy;

   ev_t sb[$];
   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   pulse_gen_multi #(
      .WD  (WD),
      .NCH (NCH)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cfg_max_cnt (cfg_max_cnt),
      .cfg_enable  (cfg_enable),
      .cfg_oneshot (cfg_oneshot),
      .cfg_cascade (cfg_cascade),
      .start       (start),
      .clk_pulse   (clk_pulse),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Keep the scoreboard ordered by cycle so the monitor only looks at the head.
   task automatic push_ev(input int c, input int ch);
      ev_t e;
      int  idx;
      e.cyc = c;
      e.ch  = ch;
      idx   = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc > c) begin
            idx = i;
            break;
         end
      end
      sb.insert(idx, e);
   endtask

   // Advance n clocks; sample 1 time unit after each edge and compare all pulses.
   task automatic run(input int n);
      logic [NCH-1:0] exp;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         cyc++;
         #1;
         exp = '0;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            if (sb[0].cyc == cyc) exp[sb[0].ch] = 1'b1;
            void'(sb.pop_front());
         end
         check($sformatf("pulse@%0d", cyc), 32'(clk_pulse), 32'(exp));
      end
   endtask

   task automatic set_max(input int ch, input int val);
      cfg_max_cnt[ch*WD +: WD] = WD'(val);
   endtask

   task automatic pulse_start(input int ch);
      start[ch] = 1'b1;
      run(1);
      start[ch] = 1'b0;
   endtask

   initial begin
      int c;
      reset_n     = 1'b1;
      cfg_max_cnt = '0;
      cfg_enable  = '0;
      cfg_oneshot = '0;
      cfg_cascade = '0;
      start       = '0;

      // Reset state
      #1 reset_n = 1'b0;
      #1;
      check("rst_pulse", 32'(clk_pulse), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      #16 reset_n = 1'b1;
      run(2);

      // Channel 0 periodic, max=9: pulses 10, 20, 30 cycles after enable edge
      set_max(0, 9);
      cfg_enable[0] = 1'b1;
      c = cyc;
      for (int k = 1; k <= 3; k++) push_ev(c + 1 + 10 * k, 0);
      run(1);
      check("a_busy_start", 32'(busy), 32'h1);
      run(34);
      check("a_busy_mid", 32'(busy), 32'h1);
      cfg_enable[0] = 1'b0;
      run(1);
      check("a_busy_off", 32'(busy), 32'h0);
      run(10);

      // Channel 1 one-shot, max=4: enable alone does not start it
      set_max(1, 4);
      cfg_oneshot[1] = 1'b1;
      cfg_enable[1]  = 1'b1;
      run(3);
      check("b_idle_wo_start", 32'(busy), 32'h0);
      c = cyc;
      push_ev(c + 6, 1);
      pulse_start(1);
      check("b_busy_run", 32'(busy), 32'h2);
      run(5);
      check("b_busy_fall", 32'(busy), 32'h0);
      run(14);
      c = cyc;
      push_ev(c + 6, 1);
      pulse_start(1);
      run(10);
      check("b_busy_end", 32'(busy), 32'h0);

      // Retrigger: starts at 0 and 3 give one pulse at 8
      c = cyc;
      push_ev(c + 9, 1);
      pulse_start(1);
      run(2);
      pulse_start(1);
      run(10);

      // Start on the terminal tick: pulse and restart
      c = cyc;
      push_ev(c + 6, 1);
      push_ev(c + 11, 1);
      pulse_start(1);
      run(4);
      pulse_start(1);
      check("e_busy_rearm", 32'(busy), 32'h2);
      run(8);
      check("e_busy_done", 32'(busy), 32'h0);
      cfg_enable[1]  = 1'b0;
      cfg_oneshot[1] = 1'b0;
      run(2);

      // Lower max below the running count
      set_max(0, 99);
      cfg_enable[0] = 1'b1;
      run(61);
      set_max(0, 10);
      c = cyc;
      push_ev(c + 1, 0);
      push_ev(c + 12, 0);
      push_ev(c + 23, 0);
      run(28);
      cfg_enable[0] = 1'b0;
      run(3);

      // max=0 periodic: pulse every cycle
      set_max(2, 0);
      cfg_enable[2] = 1'b1;
      c = cyc;
      for (int k = 2; k <= 6; k++) push_ev(c + k, 2);
      run(6);
      check("z_busy", 32'(busy), 32'h4);
      cfg_enable[2] = 1'b0;
      run(3);

      // Cascade ch1 on ch0
      set_max(0, 3);
      set_max(1, 2);
      cfg_cascade[1] = 1'b1;
      cfg_enable     = 4'b0011;
      c = cyc;
      for (int k = 1; k <= 9; k++) push_ev(c + 1 + 4 * k, 0);
`ifdef PULSE_GEN_MULTI_CASCADE_EN
      for (int k = 1; k <= 3; k++) push_ev(c + 2 + 12 * k, 1);
`else
      for (int k = 1; k <= 13; k++) push_ev(c + 1 + 3 * k, 1);
`endif
      run(40);
      cfg_enable = '0;
      run(1);
      check("c_busy_off", 32'(busy), 32'h0);
      run(5);
      cfg_cascade = '0;

      // Async reset mid-count, then restart as if first enabled
      set_max(0, 9);
      set_max(1, 4);
      cfg_oneshot[1] = 1'b1;
      cfg_enable     = 4'b0011;
      pulse_start(1);
      run(2);
      check("r_busy_pre", 32'(busy), 32'h3);
      #3 reset_n = 1'b0;
      #1;
      check("r_pulse_async", 32'(clk_pulse), 32'h0);
      check("r_busy_async", 32'(busy), 32'h0);
      run(1);
      #3 reset_n = 1'b1;
      c = cyc;
      push_ev(c + 11, 0);
      push_ev(c + 21, 0);
      run(25);
      check("r_busy_post", 32'(busy), 32'h1);
      cfg_enable = '0;
      run(3);

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
